// File: rtl/mem.sv
// MEM pipeline stage: drives the data bus for loads/stores, aligns load data, flags exceptions.
// Latency: non-access instructions take 1 cycle; bus accesses take 2+ cycles (accept edge, then the ack edge).
// Backpressure: mem_o_stall freezes the upstream pipeline while a bus access is being accepted or is outstanding.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   mem_i_*                     EX/MEM latch contents (valid, flush, wb, mem ctl, alu result, store data, rd)
//   mem_o_fwd_data              combinational copy of the ALU result for EX forwarding
//   mem_o_stall                 upstream freeze request
//   dmem_o_* / dmem_i_*         registered data-bus request; one-cycle ack with read data
//   mw_o_*                      MEM/WB register (valid, wb, rd, alu result, load data, exception code)
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_i_valid,
  input  logic        mem_i_flush,
  input  logic [1:0]  mem_i_wb,
  input  logic [4:0]  mem_i_mem,
  input  logic [31:0] mem_i_alu_result,
  input  logic [31:0] mem_i_store_data,
  input  logic [4:0]  mem_i_rd,
  output logic [31:0] mem_o_fwd_data,
  output logic        mem_o_stall,
  output logic        dmem_o_req,
  output logic        dmem_o_we,
  output logic [31:0] dmem_o_addr,
  output logic [31:0] dmem_o_wdata,
  output logic [3:0]  dmem_o_be,
  input  logic        dmem_i_ack,
  input  logic [31:0] dmem_i_rdata,
  output logic        mw_o_valid,
  output logic [1:0]  mw_o_wb,
  output logic [4:0]  mw_o_rd,
  output logic [31:0] mw_o_alu_result,
  output logic [31:0] mw_o_load_data,
  output logic [1:0]  mw_o_exc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_FUNCT3   = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  logic [0:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_flushed;
  logic [1:0]  r_wb;
  logic [4:0]  r_rd;
  logic [31:0] r_alu;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;

  logic        w_is_read;
  logic        w_is_write;
  logic [2:0]  w_f3;
  logic [1:0]  w_lo;
  logic        w_access;
  logic        w_bad_f3;
  logic        w_misal;
  logic [1:0]  w_exc;
  logic        w_legal;
  logic        w_ack;
  logic        w_timeout;
  logic        w_flush_now;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Read wins when both read and write are set.
  assign w_is_read  = mem_i_mem[0];
  assign w_is_write = mem_i_mem[1] & ~mem_i_mem[0];
  assign w_f3       = mem_i_mem[4:2];
  assign w_lo       = mem_i_alu_result[1:0];
  assign w_access   = mem_i_valid & ~mem_i_flush & (mem_i_mem[0] | mem_i_mem[1]);

  assign w_bad_f3 = w_is_read ? (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                              : (w_f3 >= 3'b011);
  // f3[1:0] encodes the access size for every legal load/store (00 byte, 01 half, 10 word).
  assign w_misal  = (w_f3[1:0] == 2'b01 && w_lo[0]) || (w_f3[1:0] == 2'b10 && w_lo != 2'b00);

  // An illegal funct3 takes precedence over misalignment.
  assign w_exc   = !w_access ? EXC_NONE : w_bad_f3 ? EXC_FUNCT3 : w_misal ? EXC_MISALIGN : EXC_NONE;
  assign w_legal = w_access & ~w_bad_f3 & ~w_misal;

  // Ack outside BUSY is ignored; ack beats a same-cycle timeout.
  assign w_ack       = (r_state == S_BUSY) & dmem_i_ack;
  assign w_timeout   = (r_state == S_BUSY) & ~dmem_i_ack & (r_cnt == 8'hFF);
  assign w_flush_now = r_flushed | mem_i_flush;

  assign mem_o_fwd_data = mem_i_alu_result;
  assign mem_o_stall    = ((r_state == S_IDLE) & w_legal) |
                          ((r_state == S_BUSY) & ~w_ack & ~w_timeout);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_i_store_data;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{mem_i_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_lo[1], 1'b0};
        w_wdata = {2{mem_i_store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_i_store_data;
      end
    endcase
  end

  // Lane select uses the low address bits captured at accept.
  assign w_shifted = dmem_i_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load = dmem_i_rdata;
    case (r_f3)
      3'b000:  w_load = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'h0, w_shifted[7:0]};
      3'b101:  w_load = {16'h0, w_shifted[15:0]};
      default: w_load = dmem_i_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= 8'h00;
      r_flushed       <= 1'b0;
      r_wb            <= 2'b00;
      r_rd            <= 5'd0;
      r_alu           <= 32'h0;
      r_f3            <= 3'b000;
      r_lane          <= 2'b00;
      dmem_o_req      <= 1'b0;
      dmem_o_we       <= 1'b0;
      dmem_o_addr     <= 32'h0;
      dmem_o_wdata    <= 32'h0;
      dmem_o_be       <= 4'b0000;
      mw_o_valid      <= 1'b0;
      mw_o_wb         <= 2'b00;
      mw_o_rd         <= 5'd0;
      mw_o_alu_result <= 32'h0;
      mw_o_load_data  <= 32'h0;
      mw_o_exc        <= EXC_NONE;
    end else if (r_state == S_IDLE) begin
      if (w_legal) begin
        r_state      <= S_BUSY;
        r_cnt        <= 8'h00;
        r_flushed    <= 1'b0;
        r_wb         <= mem_i_wb;
        r_rd         <= mem_i_rd;
        r_alu        <= mem_i_alu_result;
        r_f3         <= w_f3;
        r_lane       <= w_lo;
        dmem_o_req   <= 1'b1;
        dmem_o_we    <= w_is_write;
        dmem_o_addr  <= {mem_i_alu_result[31:2], 2'b00};
        dmem_o_wdata <= w_wdata;
        dmem_o_be    <= w_be;
        // Bubble into MEM/WB while the access is outstanding.
        mw_o_valid   <= 1'b0;
        mw_o_wb      <= 2'b00;
        mw_o_exc     <= EXC_NONE;
      end else begin
        mw_o_valid      <= mem_i_valid & ~mem_i_flush;
        mw_o_wb         <= (mem_i_valid & ~mem_i_flush & (w_exc == EXC_NONE)) ? mem_i_wb : 2'b00;
        mw_o_rd         <= mem_i_rd;
        mw_o_alu_result <= mem_i_alu_result;
        mw_o_load_data  <= 32'h0;
        mw_o_exc        <= w_exc;
      end
    end else begin
      if (w_ack | w_timeout) begin
        r_state         <= S_IDLE;
        r_cnt           <= 8'h00;
        r_flushed       <= 1'b0;
        dmem_o_req      <= 1'b0;
        dmem_o_we       <= 1'b0;
        mw_o_valid      <= ~w_flush_now;
        mw_o_wb         <= (w_flush_now | w_timeout) ? 2'b00 : r_wb;
        mw_o_rd         <= r_rd;
        mw_o_alu_result <= r_alu;
        mw_o_load_data  <= (dmem_o_we | w_timeout) ? 32'h0 : w_load;
        mw_o_exc        <= w_timeout ? EXC_TIMEOUT : EXC_NONE;
      end else begin
        r_cnt      <= r_cnt + 8'd1;
        r_flushed  <= w_flush_now;
        mw_o_valid <= 1'b0;
        mw_o_wb    <= 2'b00;
        mw_o_exc   <= EXC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_mem.sv
// Testbench for mem: table of single-cycle cases, directed multi-cycle sequences, and randomized
// accesses checked against a behavioural model built from byte/size arithmetic.
// Inputs are driven 1 ns after the rising edge; outputs are sampled before the next edge.
module tb_mem;

  logic        clk;
  logic        rst;
  logic        mem_i_valid;
  logic        mem_i_flush;
  logic [1:0]  mem_i_wb;
  logic [4:0]  mem_i_mem;
  logic [31:0] mem_i_alu_result;
  logic [31:0] mem_i_store_data;
  logic [4:0]  mem_i_rd;
  logic [31:0] mem_o_fwd_data;
  logic        mem_o_stall;
  logic        dmem_o_req;
  logic        dmem_o_we;
  logic [31:0] dmem_o_addr;
  logic [31:0] dmem_o_wdata;
  logic [3:0]  dmem_o_be;
  logic        dmem_i_ack;
  logic [31:0] dmem_i_rdata;
  logic        mw_o_valid;
  logic [1:0]  mw_o_wb;
  logic [4:0]  mw_o_rd;
  logic [31:0] mw_o_alu_result;
  logic [31:0] mw_o_load_data;
  logic [1:0]  mw_o_exc;

  int n_chk = 0;
  int n_err = 0;

  mem dut (
    .clk              (clk),
    .rst              (rst),
    .mem_i_valid      (mem_i_valid),
    .mem_i_flush      (mem_i_flush),
    .mem_i_wb         (mem_i_wb),
    .mem_i_mem        (mem_i_mem),
    .mem_i_alu_result (mem_i_alu_result),
    .mem_i_store_data (mem_i_store_data),
    .mem_i_rd         (mem_i_rd),
    .mem_o_fwd_data   (mem_o_fwd_data),
    .mem_o_stall      (mem_o_stall),
    .dmem_o_req       (dmem_o_req),
    .dmem_o_we        (dmem_o_we),
    .dmem_o_addr      (dmem_o_addr),
    .dmem_o_wdata     (dmem_o_wdata),
    .dmem_o_be        (dmem_o_be),
    .dmem_i_ack       (dmem_i_ack),
    .dmem_i_rdata     (dmem_i_rdata),
    .mw_o_valid       (mw_o_valid),
    .mw_o_wb          (mw_o_wb),
    .mw_o_rd          (mw_o_rd),
    .mw_o_alu_result  (mw_o_alu_result),
    .mw_o_load_data   (mw_o_load_data),
    .mw_o_exc         (mw_o_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    logic        v;
    logic        fl;
    logic [1:0]  wb;
    logic [4:0]  mm;
    logic [31:0] a;
    logic [4:0]  rd;
    logic        e_stall;
    logic        e_valid;
    logic [1:0]  e_wb;
    logic [1:0]  e_exc;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f);
    return 1 << (int'(f) % 4);
  endfunction

  function automatic logic [1:0] m_exc(input logic [4:0] mm, input logic [31:0] a);
    int  f;
    bit  ok;
    f = int'(mm[4:2]);
    if (mm[0]) ok = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
    else       ok = (f <= 2);
    if (!ok) return 2'b10;
    if ((int'(a[1:0]) % m_size(mm[4:2])) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    int m;
    m = ((1 << m_size(f)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
    logic [31:0] w;
    int s;
    s = m_size(f);
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
    int s;
    logic [31:0] v;
    logic [31:0] full;
    s = m_size(f);
    if (s == 4) return rd;
    v    = rd >> (8 * int'(a[1:0]));
    full = 32'd1 << (8 * s);
    v    = v % full;
    if (f < 3'd4 && v >= (full >> 1)) v = v - full;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_i_valid = 1'b0;
    mem_i_flush = 1'b0;
    mem_i_mem   = 5'd0;
    dmem_i_ack  = 1'b0;
  endtask

  // Presents one instruction (starting just after a rising edge) and follows it to completion.
  // delay = BUSY cycles without ack; delay > 255 means no ack at all (timeout).
  task automatic issue(input logic v, input logic fl, input logic [1:0] wb, input logic [4:0] mm,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input int delay, input logic [31:0] rdata, input int flush_at,
                       output int stalls);
    logic       acc, st, legal, tmo, flushed;
    logic [1:0] ex;
    int         nb;
    acc     = v & ~fl & (mm[0] | mm[1]);
    st      = mm[1] & ~mm[0];
    ex      = acc ? m_exc(mm, a) : 2'b00;
    legal   = acc && (ex == 2'b00);
    tmo     = (delay > 255);
    nb      = tmo ? 255 : delay;
    flushed = (flush_at >= 0) && (flush_at <= nb);
    stalls  = 0;

    mem_i_valid = v; mem_i_flush = fl; mem_i_wb = wb; mem_i_mem = mm;
    mem_i_alu_result = a; mem_i_store_data = sd; mem_i_rd = rd; dmem_i_ack = 1'b0;
    #1;
    if (mem_o_stall) stalls++;
    chk("stall_at_accept", mem_o_stall, legal);
    chk("fwd_data", mem_o_fwd_data, a);
    @(posedge clk); #1;

    if (!legal) begin
      chk("no_req", dmem_o_req, 1'b0);
      chk("mw_valid", mw_o_valid, v & ~fl);
      chk("mw_exc", mw_o_exc, ex);
      if (v & ~fl) begin
        chk("mw_wb", mw_o_wb, (ex != 2'b00) ? 2'b00 : wb);
        chk("mw_rd", mw_o_rd, rd);
      end
      if (acc) chk("mw_load_exc", mw_o_load_data, 32'h0);
      idle_inputs();
    end else begin
      chk("req_set", dmem_o_req, 1'b1);
      chk("we", dmem_o_we, st);
      chk("addr", dmem_o_addr, {a[31:2], 2'b00});
      chk("bubble_valid", mw_o_valid, 1'b0);
      if (st) begin
        chk("be", dmem_o_be, m_be(mm[4:2], a));
        chk("wdata", dmem_o_wdata, m_wdata(mm[4:2], sd));
      end
      for (int k = 0; k < nb; k++) begin
        mem_i_flush = (k == flush_at);
        #1;
        if (mem_o_stall) stalls++;
        chk("stall_busy", mem_o_stall, 1'b1);
        @(posedge clk); #1;
        chk("req_held", dmem_o_req, 1'b1);
      end
      mem_i_flush = (nb == flush_at);
      if (!tmo) begin
        dmem_i_ack   = 1'b1;
        dmem_i_rdata = rdata;
      end
      #1;
      if (mem_o_stall) stalls++;
      chk("stall_exit", mem_o_stall, 1'b0);
      @(posedge clk); #1;
      idle_inputs();
      chk("req_drop", dmem_o_req, 1'b0);
      chk("fin_valid", mw_o_valid, !flushed);
      chk("fin_wb", mw_o_wb, (flushed || tmo) ? 2'b00 : wb);
      chk("fin_rd", mw_o_rd, rd);
      chk("fin_alu", mw_o_alu_result, a);
      chk("fin_exc", mw_o_exc, tmo ? 2'b11 : 2'b00);
      chk("fin_load", mw_o_load_data, (st || tmo) ? 32'h0 : m_load(mm[4:2], a, rdata));
    end
  endtask

  initial begin
    int          st_cnt;
    logic [2:0]  ld_ok [5];
    logic [31:0] r;
    logic [1:0]  rw, lo;
    logic [2:0]  f3;
    int          dl, fa;

    ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    //            v     fl    wb     mm         a             rd    stall valid  wb     exc
    vt[0]  = '{1'b1, 1'b0, 2'b01, 5'b00000, 32'h0000_1111, 5'd3, 1'b0, 1'b1, 2'b01, 2'b00};
    vt[1]  = '{1'b0, 1'b0, 2'b01, 5'b01001, 32'h0000_0100, 5'd4, 1'b0, 1'b0, 2'b00, 2'b00};
    vt[2]  = '{1'b1, 1'b1, 2'b01, 5'b01001, 32'h0000_0100, 5'd5, 1'b0, 1'b0, 2'b00, 2'b00};
    vt[3]  = '{1'b1, 1'b0, 2'b01, 5'b01001, 32'h0000_3001, 5'd6, 1'b0, 1'b1, 2'b00, 2'b01};
    vt[4]  = '{1'b1, 1'b0, 2'b01, 5'b00110, 32'h0000_2003, 5'd7, 1'b0, 1'b1, 2'b00, 2'b01};
    vt[5]  = '{1'b1, 1'b0, 2'b11, 5'b00101, 32'h0000_0011, 5'd8, 1'b0, 1'b1, 2'b00, 2'b01};
    vt[6]  = '{1'b1, 1'b0, 2'b01, 5'b01101, 32'h0000_0040, 5'd9, 1'b0, 1'b1, 2'b00, 2'b10};
    vt[7]  = '{1'b1, 1'b0, 2'b01, 5'b11001, 32'h0000_0040, 5'd10, 1'b0, 1'b1, 2'b00, 2'b10};
    vt[8]  = '{1'b1, 1'b0, 2'b01, 5'b01110, 32'h0000_0040, 5'd11, 1'b0, 1'b1, 2'b00, 2'b10};
    vt[9]  = '{1'b1, 1'b0, 2'b01, 5'b10010, 32'h0000_0040, 5'd12, 1'b0, 1'b1, 2'b00, 2'b10};
    vt[10] = '{1'b1, 1'b0, 2'b01, 5'b11111, 32'h0000_0040, 5'd13, 1'b0, 1'b1, 2'b00, 2'b10};
    vt[11] = '{1'b1, 1'b0, 2'b01, 5'b01010, 32'h0000_0042, 5'd14, 1'b0, 1'b1, 2'b00, 2'b01};
    vt[12] = '{1'b1, 1'b0, 2'b01, 5'b01011, 32'h0000_0041, 5'd15, 1'b0, 1'b1, 2'b00, 2'b01};

    rst = 1'b0;
    mem_i_wb = 2'b00; mem_i_alu_result = 32'h0; mem_i_store_data = 32'h0; mem_i_rd = 5'd0;
    dmem_i_rdata = 32'h0;
    idle_inputs();
    #2;
    chk("rst_req", dmem_o_req, 1'b0);
    chk("rst_we", dmem_o_we, 1'b0);
    chk("rst_addr", dmem_o_addr, 32'h0);
    chk("rst_wdata", dmem_o_wdata, 32'h0);
    chk("rst_be", dmem_o_be, 4'h0);
    chk("rst_mw_valid", mw_o_valid, 1'b0);
    chk("rst_mw_wb", mw_o_wb, 2'b00);
    chk("rst_mw_load", mw_o_load_data, 32'h0);
    chk("rst_mw_exc", mw_o_exc, 2'b00);
    chk("rst_stall", mem_o_stall, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single-cycle table
    for (int i = 0; i < 13; i++) begin
      mem_i_valid = vt[i].v; mem_i_flush = vt[i].fl; mem_i_wb = vt[i].wb; mem_i_mem = vt[i].mm;
      mem_i_alu_result = vt[i].a; mem_i_rd = vt[i].rd;
      #1;
      chk("tbl_stall", mem_o_stall, vt[i].e_stall);
      @(posedge clk); #1;
      chk("tbl_req", dmem_o_req, 1'b0);
      chk("tbl_valid", mw_o_valid, vt[i].e_valid);
      chk("tbl_exc", mw_o_exc, vt[i].e_exc);
      if (vt[i].e_valid) chk("tbl_wb", mw_o_wb, vt[i].e_wb);
      idle_inputs();
    end

    // LB a=0x1003, three BUSY cycles without ack
    issue(1'b1, 1'b0, 2'b01, 5'b00001, 32'h0000_1003, 32'h0, 5'd1, 3, 32'h80FF_FF00, -1, st_cnt);
    chk("lb_data", mw_o_load_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", st_cnt, 4);

    // SH a=0x2002: check lanes on the bus while it is outstanding
    mem_i_valid = 1'b1; mem_i_flush = 1'b0; mem_i_wb = 2'b00; mem_i_mem = 5'b00110;
    mem_i_alu_result = 32'h0000_2002; mem_i_store_data = 32'h0000_ABCD; mem_i_rd = 5'd0;
    @(posedge clk); #1;
    chk("sh_be", dmem_o_be, 4'b1100);
    chk("sh_wdata", dmem_o_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_o_addr, 32'h0000_2000);
    chk("sh_we", dmem_o_we, 1'b1);
    dmem_i_ack = 1'b1; dmem_i_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    idle_inputs();
    chk("sh_load_zero", mw_o_load_data, 32'h0);
    chk("sh_valid", mw_o_valid, 1'b1);

    // LW misaligned: immediate exception, no stall
    issue(1'b1, 1'b0, 2'b01, 5'b01001, 32'h0000_3001, 32'h0, 5'd2, 0, 32'h0, -1, st_cnt);
    chk("lw_mis_exc", mw_o_exc, 2'b01);
    chk("lw_mis_stall", st_cnt, 0);

    // flush two cycles into a BUSY load
    issue(1'b1, 1'b0, 2'b01, 5'b01001, 32'h0000_5000, 32'h0, 5'd3, 4, 32'hCAFE_F00D, 2, st_cnt);
    chk("flush_valid", mw_o_valid, 1'b0);

    // ack and timeout in the same cycle resolve as ack
    issue(1'b1, 1'b0, 2'b01, 5'b01001, 32'h0000_7000, 32'h0, 5'd4, 255, 32'h0BAD_BEEF, -1, st_cnt);
    chk("ack_tmo_exc", mw_o_exc, 2'b00);

    // no ack at all: timeout
    issue(1'b1, 1'b0, 2'b01, 5'b01001, 32'h0000_6000, 32'h0, 5'd5, 300, 32'h0, -1, st_cnt);
    chk("tmo_exc", mw_o_exc, 2'b11);
    chk("tmo_stall_cycles", st_cnt, 256);
    issue(1'b1, 1'b0, 2'b01, 5'b00000, 32'h0000_0042, 32'h0, 5'd7, 0, 32'h0, -1, st_cnt);
    chk("add_after_tmo_valid", mw_o_valid, 1'b1);
    chk("add_after_tmo_stall", st_cnt, 0);

    // reset mid-BUSY, then a late ack
    mem_i_valid = 1'b1; mem_i_flush = 1'b0; mem_i_wb = 2'b01; mem_i_mem = 5'b01001;
    mem_i_alu_result = 32'h0000_4000; mem_i_rd = 5'd9;
    @(posedge clk); #1;
    chk("mid_req_before", dmem_o_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", dmem_o_req, 1'b0);
    chk("mid_rst_addr", dmem_o_addr, 32'h0);
    chk("mid_rst_mw_valid", mw_o_valid, 1'b0);
    chk("mid_rst_mw_rd", mw_o_rd, 5'd0);
    chk("mid_rst_mw_alu", mw_o_alu_result, 32'h0);
    chk("mid_rst_exc", mw_o_exc, 2'b00);
    mem_i_valid = 1'b0; mem_i_mem = 5'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_i_ack = 1'b1; dmem_i_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_i_ack = 1'b0;
    chk("late_ack_valid", mw_o_valid, 1'b0);
    chk("late_ack_req", dmem_o_req, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      rw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) f3 = rw[0] ? ld_ok[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      lo = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      r  = $urandom();
      dl = $urandom_range(0, 4);
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dl) : -1;
      issue(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
            {f3, rw}, {r[31:2], lo}, $urandom(), 5'($urandom_range(0, 31)), dl, $urandom(), fa, st_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 The block SHALL have ports, clock and reset first, as listed below.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_i_valid  in  1  EX/MEM latch holds a live instruction.
- mem_i_flush  in  1  control-unit kill of the MEM-stage instruction.
- mem_i_wb  in  2  writeback control carried from EX.
- mem_i_mem  in  5  [0] read, [1] write, [4:2] funct3.
- mem_i_alu_result  in  32  effective address or ALU result.
- mem_i_store_data  in  32  rs2 value for stores.
- mem_i_rd  in  5  destination register.
- mem_o_fwd_data  out  32  combinational copy of mem_i_alu_result; feeds the EX-stage forwarding mux.
- mem_o_stall  out  1  freeze IF/ID/EX and the EX/MEM latch.
- dmem_o_req  out  1  bus request, registered.
- dmem_o_we  out  1  write enable, registered.
- dmem_o_addr  out  32  word-aligned address ([1:0]=0), registered.
- dmem_o_wdata  out  32  lane-shifted store data, registered.
- dmem_o_be  out  4  byte enables, registered.
- dmem_i_ack  in  1  one-cycle completion pulse.
- dmem_i_rdata  in  32  read word, valid with ack.
- mw_o_valid, mw_o_wb[1:0], mw_o_rd[4:0], mw_o_alu_result[32], mw_o_load_data[32]  out  MEM/WB register contents.
- mw_o_exc  out  2  00 none, 01 misaligned, 10 bad funct3, 11 bus timeout.

Function
REQ-002 Access SHALL mean mem_i_valid & ~mem_i_flush & (read|write); read and write both set SHALL be treated as read.
REQ-003 Non-access instructions SHALL reach mw_o_* on the next edge: mw_o_valid=mem_i_valid&~flush, with no stall.
REQ-004 FSM states SHALL be IDLE and BUSY; IDLE->BUSY on an accepted legal access; BUSY->IDLE on dmem_i_ack or on timeout.
REQ-005 On IDLE->BUSY the block SHALL register req=1, we, addr, wdata, and be; it SHALL hold them stable until leaving BUSY, then deassert req.
REQ-006 mem_o_stall SHALL be 1 when (IDLE & legal access) | (BUSY & ~ack & ~timeout), and 0 otherwise.
REQ-007 Minimum access latency SHALL be 2 cycles (accept edge, then ack); MEM/WB SHALL update on the edge where ack is sampled.
REQ-008 Byte enables SHALL be: SB 0001<<a[1:0]; SH 0011<<{a[1],0}; SW 1111; wdata SHALL be rs2 replicated into the lanes.
REQ-009 Loads SHALL select a lane by a[1:0]; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass through.
REQ-010 Misalignment (LH/LHU/SH with a[0]=1; LW/SW with a[1:0]!=0) SHALL issue no bus request and SHALL set exc=01.
REQ-011 Illegal funct3 (load 011/110/111; store >=011) SHALL issue no bus request and SHALL set exc=10.
REQ-012 Whenever exc!=00, the block SHALL latch mw_o_valid=1, mw_o_wb=0, and mw_o_load_data=0 in one cycle.
REQ-013 An 8-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without ack; at 255 the block SHALL go IDLE with exc=11 and wb=0.
REQ-014 mem_i_flush in IDLE SHALL kill the access (no req); flush in BUSY SHALL NOT abort the bus, the transaction SHALL complete, and the result SHALL be written with mw_o_valid=0 and wb=0.
REQ-015 A flush seen at any BUSY cycle SHALL be remembered in a sticky bit until exit.
REQ-016 Ack and timeout in the same cycle SHALL resolve as ack (no exception).
REQ-017 Ack while in IDLE SHALL be ignored.
REQ-018 The registered copies of rd, wb, and alu_result SHALL be captured at accept so that result writeback does not depend on latch inputs during BUSY.
REQ-019 Stores SHALL write mw_o_load_data=0.

Reset
REQ-020 rst=0 SHALL asynchronously force state=IDLE, counter=0, sticky flush=0, and all registered outputs to 0, including dmem_o_*, mw_o_*, and exc.
REQ-021 Reset asserted mid-BUSY SHALL drop dmem_o_req immediately; the pending transaction SHALL be abandoned and a late ack SHALL be ignored.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- LB a=0x1003, ack after 3 cycles with rdata=0x80FF_FF00 -> load_data=0xFFFF_FF80, stall high exactly 4 cycles.
- SH a=0x2002, rs2=0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, addr=0x2000, we=1, load_data=0.
- LW a=0x3001 -> no req, exc=01, wb=00, mw_o_valid=1, no stall.
- Flush asserted 2 cycles into a BUSY load -> req held until ack, then mw_o_valid=0.
- No ack for 255 cycles -> exc=11, req drops, stall drops; then an ADD passes in 1 cycle.
- rst low mid-BUSY -> all outputs 0 the same cycle; an ack 1 cycle later causes no mw_o_valid.
